booth_ctrl: RTL and testbench
=============================

# booth_ctrl

Control unit that sequences the 5-bit radix-2 Booth multiplier datapath (multiplicand register Y, accumulator F, multiplier/shift register S, previous-bit register R, add/sub unit, output mux). It accepts a start request, loads the two operands from the shared `data_in` bus, runs one evaluate/shift iteration per multiplier bit, then presents the 10-bit signed product as a high word followed by a low word on `data_out`. It is a Moore FSM with an iteration counter. Each control output is a pure decode of registered state. It drives only datapath control pins and never touches data.

## Interface
- `WIDTH`, 5: operand width. Sets the iteration count and must equal the datapath width.
- `CNT_W`, 3: iteration counter width. Requires 2^CNT_W > WIDTH.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `m1` in 1: current multiplier LSB (S shift-out) from the datapath.
- `m0` in 1: previous multiplier bit (R register) from the datapath.
- `ldy` out 1: load Y from `data_in`.
- `lds` out 1: load S from `data_in`.
- `sclrf` out 1: synchronous clear of F.
- `sclrr` out 1: synchronous clear of R.
- `ldf` out 1: load F with the add/sub result.
- `addsub` out 1: 1 means F−Y, 0 means F+Y.
- `shf` out 1: arithmetic right shift of F. The F LSB goes to the S MSB.
- `shs` out 1: right shift of S.
- `ldr` out 1: load R with the S LSB.
- `sel` out 1: output mux select. 0 selects F (high word), 1 selects S (low word).
- `busy` out 1: high in every state except IDLE.
- `hi_valid` out 1: `data_out` holds the product high word.
- `done` out 1: `data_out` holds the product low word. Single-cycle pulse.

## Operation
States, one cycle each unless looping:
- IDLE: all outputs 0. Go to LD_Y when `start`=1.
- LD_Y: `ldy`=1. The external source must drive the multiplicand on `data_in` in this cycle. Go to LD_S.
- LD_S: `lds`=`sclrf`=`sclrr`=1. The external source must drive the multiplier on `data_in`. Clear the counter to 0. Go to EVAL.
- EVAL: decode {`m1`,`m0`}.
  - 10: `ldf`=1, `addsub`=1.
  - 01: `ldf`=1, `addsub`=0.
  - 00 or 11: `ldf`=0, `addsub`=0.
  - Go to SHIFT.
- SHIFT: `shf`=`shs`=`ldr`=1. Increment the counter. Go to RES_HI if the counter was WIDTH−1, otherwise go to EVAL.
- RES_HI: `sel`=0, `hi_valid`=1. Go to RES_LO.
- RES_LO: `sel`=1, `done`=1. Go to IDLE.

Rules:
- The EVAL cycle is always spent, even for 00/11. Latency is fixed and independent of operand values.
- `ldf` and `shf` are never asserted in the same cycle.
- `lds` and `shs` are never asserted together.
- `sclrr` and `ldr` are never asserted together.
- Encodings outside the defined states go to IDLE on the next edge.

## Timing
- Reset: while `rst_n`=0 at a rising edge, the state becomes IDLE and the counter becomes 0. Every output is 0 in the following cycle: `busy`, `done`, `hi_valid`, `sel` and all load/shift/clear strobes.
- Reset mid-operation aborts the multiply. No `done` is issued. Datapath contents are don't-care.
- Let cycle 0 be the cycle in which IDLE samples `start`=1.
  - LD_Y is cycle 1. LD_S is cycle 2.
  - EVAL/SHIFT pairs occupy cycles 3–12.
  - RES_HI is cycle 13. RES_LO is cycle 14.
  - IDLE is cycle 15. A new `start` can be accepted in cycle 15.
- General total: 2·WIDTH+5 cycles from `start` to the return to IDLE.
- `start` is ignored while `busy`=1. A `start` held high through RES_LO is accepted in IDLE in cycle 15.
- `data_out` is valid at the end of cycles 13 and 14, one register delay after the final shift.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 → all outputs 0, state IDLE. Release reset → LD_Y follows one cycle after `start` is sampled.
- 7×3: `data_in`=00111, then 00011 → `hi_valid` in cycle 13 with `data_out`=00000. `done` in cycle 14 with `data_out`=10101 (21).
- −3×5: `data_in`=11101, then 00101 → high word 11111, low word 10001 (−15).
- −16×−16: `data_in`=10000, then 10000 → high word 01000, low word 00000 (256). Checks the arithmetic shift on the extreme operands.
- Multiplier 01010 with any multiplicand → `ldf` pulses in EVAL of iterations 1–4 only, with `addsub` = 1, 0, 1, 0. No `ldf` in iteration 0.
- Abort and busy: assert `rst_n`=0 at cycle 6 → IDLE and no `done`. Then pulse `start` during a running op at cycle 5 → ignored, and exactly one `done` appears at cycle 14.

Source files
------------

// File: rtl/booth_ctrl.sv
// booth_ctrl: Moore sequencer for a radix-2 Booth multiplier datapath (load, WIDTH eval/shift iterations, high/low result)
module booth_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic m1,
    input  logic m0,
    output logic ldy,
    output logic lds,
    output logic sclrf,
    output logic sclrr,
    output logic ldf,
    output logic addsub,
    output logic shf,
    output logic shs,
    output logic ldr,
    output logic sel,
    output logic busy,
    output logic hi_valid,
    output logic done
);
    typedef enum logic [2:0] {IDLE, LD_Y, LD_S, EVAL, SHIFT, RES_HI, RES_LO} state_t;
    state_t state, next_state;
    logic [CNT_W-1:0] cnt;
    logic last_iter;
    assign last_iter = cnt == CNT_W'(WIDTH - 1);
    // state register and iteration counter; counter clears on operand load, steps on every shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= state == LD_S ? '0 : state == SHIFT ? cnt + CNT_W'(1) : cnt;
        end
    end
    // next-state: fixed-latency sequence, illegal encodings fall back to IDLE
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = start ? LD_Y : IDLE;
            LD_Y:    next_state = LD_S;
            LD_S:    next_state = EVAL;
            EVAL:    next_state = SHIFT;
            SHIFT:   next_state = last_iter ? RES_HI : EVAL;
            RES_HI:  next_state = RES_LO;
            RES_LO:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    // output decode; EVAL qualifies the add/sub strobe with the Booth bit pair {m1,m0}
    always_comb begin
        ldy      = state == LD_Y;
        lds      = state == LD_S;
        sclrf    = state == LD_S;
        sclrr    = state == LD_S;
        ldf      = state == EVAL && (m1 ^ m0);
        addsub   = state == EVAL && m1 && !m0;
        shf      = state == SHIFT;
        shs      = state == SHIFT;
        ldr      = state == SHIFT;
        sel      = state == RES_LO;
        busy     = state != IDLE;
        hi_valid = state == RES_HI;
        done     = state == RES_LO;
    end
endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: checks booth_ctrl sequencing and, through a behavioural datapath, the signed products
module tb_booth_ctrl;
    localparam int W = 5;
    localparam int LAST = 2 * W + 5;
    logic clk = 1'b0;
    logic rst_n, start, m1, m0;
    logic ldy, lds, sclrf, sclrr, ldf, addsub, shf, shs, ldr, sel, busy, hi_valid, done;
    logic [W-1:0] data_in, data_out;
    logic [W:0] f = '0;
    logic [W-1:0] y = '0, s = '0;
    logic r = 1'b0;
    int checks = 0;
    int errors = 0;

    booth_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m1(m1), .m0(m0),
        .ldy(ldy), .lds(lds), .sclrf(sclrf), .sclrr(sclrr), .ldf(ldf), .addsub(addsub),
        .shf(shf), .shs(shs), .ldr(ldr), .sel(sel), .busy(busy), .hi_valid(hi_valid), .done(done)
    );

    always #5 clk = ~clk;

    // datapath with one guard bit on F so the arithmetic shift keeps the true sign
    always @(posedge clk) begin
        if (ldy) y <= data_in;
        if (sclrf) f <= '0;
        else if (ldf) f <= addsub ? f - {y[W-1], y} : f + {y[W-1], y};
        else if (shf) f <= {f[W], f[W:1]};
        if (lds) s <= data_in;
        else if (shs) s <= {f[0], s[W-1:1]};
        if (sclrr) r <= 1'b0;
        else if (ldr) r <= s[0];
    end
    assign m1 = s[0];
    assign m0 = r;
    assign data_out = sel ? s : f[W-1:0];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [12:0] ctl_vec();
        return {ldy, lds, sclrf, sclrr, ldf, addsub, shf, shs, ldr, sel, busy, hi_valid, done};
    endfunction

    // expected strobes for cycle k after start (k=0 is the IDLE cycle that samples start)
    function automatic logic [12:0] exp_ctl(input int k, input logic [W-1:0] b);
        logic e_ldy, e_lds, e_ldf, e_add, e_sh, cur, prev;
        int i;
        e_ldy = k == 1;
        e_lds = k == 2;
        e_ldf = 1'b0;
        e_add = 1'b0;
        e_sh  = 1'b0;
        if (k >= 3 && k <= 2 * W + 2) begin
            i = (k - 3) / 2;
            if ((k - 3) % 2 == 0) begin
                cur  = b[i];
                prev = 1'b0;
                if (i > 0) prev = b[i-1];
                e_ldf = cur ^ prev;
                e_add = cur & ~prev;
            end else e_sh = 1'b1;
        end
        return {e_ldy, e_lds, e_lds, e_lds, e_ldf, e_add, e_sh, e_sh, e_sh,
                k == LAST - 1, k >= 1 && k <= LAST - 1, k == LAST - 2, k == LAST - 1};
    endfunction

    // caller is at a negedge in IDLE; this is cycle 0, ends at the negedge of cycle LAST (IDLE again)
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int st_lo, input int st_hi, input int abort_at);
        int p, done_cnt;
        logic [2*W-1:0] pw;
        logic aborted;
        p = int'($signed(a)) * int'($signed(b));
        pw = (2*W)'(p);
        done_cnt = 0;
        aborted = 1'b0;
        chk({name, "_idle"}, 16'(ctl_vec()), 16'(0));
        rst_n = 1'b1;
        start = 1'b1;
        data_in = W'($urandom);
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            if (abort_at > 0 && k > abort_at) aborted = 1'b1;
            done_cnt += int'(done);
            chk($sformatf("%s_ctl%0d", name, k), 16'(ctl_vec()), aborted ? 16'(0) : 16'(exp_ctl(k, b)));
            if (!aborted && k == LAST - 2) chk({name, "_hi"}, 16'(data_out), 16'(pw[2*W-1:W]));
            if (!aborted && k == LAST - 1) chk({name, "_lo"}, 16'(data_out), 16'(pw[W-1:0]));
            start = k >= st_lo && k <= st_hi;
            rst_n = !(k == abort_at);
            data_in = k == 1 ? a : k == 2 ? b : W'($urandom);
        end
        chk({name, "_done_count"}, 16'(done_cnt), abort_at > 0 ? 16'(0) : 16'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        data_in = '0;
        @(negedge clk);
        chk("reset_c1", 16'(ctl_vec()), 16'(0));
        @(negedge clk);
        run_op("mul_7x3", 5'b00111, 5'b00011, -1, -1, -1);
        run_op("mul_m3x5", 5'b11101, 5'b00101, -1, -1, -1);
        run_op("mul_m16xm16", 5'b10000, 5'b10000, -1, -1, -1);
        run_op("mult_01010", W'($urandom), 5'b01010, -1, -1, -1);
        run_op("abort", W'($urandom), W'($urandom), -1, -1, 6);
        run_op("start_ignored", W'($urandom), W'($urandom), 5, 5, -1);
        run_op("start_held", W'($urandom), W'($urandom), 1, LAST - 1, -1);
        run_op("after_held", W'($urandom), W'($urandom), -1, -1, -1);
        for (int n = 0; n < 10; n++) run_op($sformatf("rand%0d", n), W'($urandom), W'($urandom), -1, -1, -1);
        start = 1'b0;
        @(negedge clk);
        chk("final_idle", 16'(ctl_vec()), 16'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
